// File: rtl/enigma_pkg.sv
// Shared types and constants for the substitution-table stages.
package enigma_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } table_state_e;

  localparam logic [1:0] TBL_ROTOR     = 2'b00;
  localparam logic [1:0] TBL_REFLECTOR = 2'b01;
  localparam logic [1:0] TBL_PLUGBOARD = 2'b10;

  localparam int unsigned CODE_W_DEF = 6;

endpackage

// File: rtl/subst_search.sv
// Combinational DEPTH-way equality compare with lowest-index priority encode.
module subst_search #(
  parameter int unsigned CODE_W = 6,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH*CODE_W-1:0] i_flat,
  input  logic [CODE_W-1:0]       i_code,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_hit
);

  always_comb begin
    o_idx = '0;
    o_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!o_hit && (i_flat[i*CODE_W +: CODE_W] == i_code)) begin
        o_idx = IDX_W'(i);
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/subst_table_bank.sv
// Serially loaded DEPTH x CODE_W substitution table with fill tracking and
// registered lookup. Inverse lookup is built only when SUBST_INVERSE_EN is defined.
module subst_table_bank
  import enigma_pkg::*;
#(
  parameter int unsigned             CODE_W      = CODE_W_DEF,
  parameter int unsigned             DEPTH       = 32,
  parameter int unsigned             TABLE_IDX_W = 2,
  parameter logic [TABLE_IDX_W-1:0]  TABLE_ID    = TABLE_IDX_W'(TBL_PLUGBOARD),
  localparam int unsigned            IDX_W       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TABLE_IDX_W-1:0]    table_idx,
  input  logic                      load,
  input  logic [CODE_W-1:0]         code_in,
  input  logic                      clear,
  input  logic                      lookup_valid,
  input  logic [IDX_W-1:0]          lookup_idx,
  output logic                      result_valid,
  output logic [CODE_W-1:0]         result_code,
  output logic                      result_err,
  output logic                      result_stale,
  output logic [IDX_W:0]            load_count,
  output logic                      table_ready,
  output logic [DEPTH*CODE_W-1:0]   table_flat,
  input  logic                      inv_valid,
  input  logic [CODE_W-1:0]         inv_code,
  output logic                      inv_result_valid,
  output logic [IDX_W-1:0]          inv_idx,
  output logic                      inv_hit
);

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  logic [CODE_W-1:0] r_table [DEPTH];
  table_state_e      r_state, w_state_nxt;
  logic [IDX_W:0]    r_count, w_count_nxt;
  logic              w_ld, w_ready, w_idx_oob;
  logic              r_res_valid, r_res_err, r_res_stale;
  logic [CODE_W-1:0] r_res_code;

  assign w_ld = load && (table_idx == TABLE_ID);

  if (DEPTH == (2**IDX_W)) begin : g_pow2
    assign w_idx_oob = 1'b0;
  end else begin : g_npow2
    assign w_idx_oob = (lookup_idx >= IDX_W'(DEPTH));
  end

  // Shift register: new codes enter at the top, so after DEPTH loads entry[i] = c_i.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_table[i] <= CODE_W'(i);
    end else if (w_ld) begin
      for (int unsigned i = 0; i < DEPTH-1; i++) r_table[i] <= r_table[i+1];
      r_table[DEPTH-1] <= code_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (clear) begin
      w_state_nxt = EMPTY;
      w_count_nxt = '0;
    end else if (w_ld) begin
      if (r_count != DEPTH_C) w_count_nxt = r_count + (IDX_W+1)'(1);
      case (r_state)
        EMPTY:   w_state_nxt = FILLING;
        FILLING: if (r_count == DEPTH_C - (IDX_W+1)'(1)) w_state_nxt = READY;
        READY:   w_state_nxt = READY;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    w_ready = (r_state == READY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_code  <= '0;
      r_res_err   <= 1'b0;
      r_res_stale <= 1'b0;
    end else begin
      r_res_valid <= lookup_valid;
      if (lookup_valid) begin
        r_res_stale <= !w_ready;
        r_res_err   <= w_idx_oob;
        r_res_code  <= w_idx_oob ? '0 : r_table[lookup_idx];
      end
    end
  end

  always_comb begin
    table_flat = '0;
    for (int unsigned i = 0; i < DEPTH; i++) table_flat[i*CODE_W +: CODE_W] = r_table[i];
  end

  assign result_valid = r_res_valid;
  assign result_code  = r_res_code;
  assign result_err   = r_res_err;
  assign result_stale = r_res_stale;
  assign load_count   = r_count;
  assign table_ready  = w_ready;

`ifdef SUBST_INVERSE_EN
  logic [IDX_W-1:0] w_inv_idx, r_inv_idx;
  logic             w_inv_hit, r_inv_hit, r_inv_valid;

  subst_search #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_search (
    .i_flat (table_flat),
    .i_code (inv_code),
    .o_idx  (w_inv_idx),
    .o_hit  (w_inv_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inv_valid <= 1'b0;
      r_inv_idx   <= '0;
      r_inv_hit   <= 1'b0;
    end else begin
      r_inv_valid <= inv_valid;
      if (inv_valid) begin
        r_inv_idx <= w_inv_idx;
        r_inv_hit <= w_inv_hit;
      end
    end
  end

  assign inv_result_valid = r_inv_valid;
  assign inv_idx          = r_inv_idx;
  assign inv_hit          = r_inv_hit;
`else
  logic w_unused_inv;
  assign w_unused_inv     = ^{inv_valid, inv_code};
  assign inv_result_valid = 1'b0;
  assign inv_idx          = '0;
  assign inv_hit          = 1'b0;
`endif

endmodule

// File: tb/tb_subst_table_bank.sv
// Bench for subst_table_bank: directed plan steps plus randomized traffic against a queue model.
module tb_subst_table_bank;
  import enigma_pkg::*;

  localparam int unsigned CODE_W = 6;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned TIW    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [TIW-1:0]          table_idx;
  logic                    load;
  logic [CODE_W-1:0]       code_in;
  logic                    clear;
  logic                    lookup_valid;
  logic [IDX_W-1:0]        lookup_idx;
  logic                    result_valid;
  logic [CODE_W-1:0]       result_code;
  logic                    result_err;
  logic                    result_stale;
  logic [IDX_W:0]          load_count;
  logic                    table_ready;
  logic [DEPTH*CODE_W-1:0] table_flat;
  logic                    inv_valid;
  logic [CODE_W-1:0]       inv_code;
  logic                    inv_result_valid;
  logic [IDX_W-1:0]        inv_idx;
  logic                    inv_hit;

  always #5 clk = ~clk;

  subst_table_bank #(
    .CODE_W      (CODE_W),
    .DEPTH       (DEPTH),
    .TABLE_IDX_W (TIW),
    .TABLE_ID    (TBL_PLUGBOARD)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .table_idx        (table_idx),
    .load             (load),
    .code_in          (code_in),
    .clear            (clear),
    .lookup_valid     (lookup_valid),
    .lookup_idx       (lookup_idx),
    .result_valid     (result_valid),
    .result_code      (result_code),
    .result_err       (result_err),
    .result_stale     (result_stale),
    .load_count       (load_count),
    .table_ready      (table_ready),
    .table_flat       (table_flat),
    .inv_valid        (inv_valid),
    .inv_code         (inv_code),
    .inv_result_valid (inv_result_valid),
    .inv_idx          (inv_idx),
    .inv_hit          (inv_hit)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference: the table is a queue of DEPTH codes; a load appends and drops the oldest.
  int          m_tab[$];
  int          m_cnt;
  logic        e_rv, e_err, e_stale, e_irv, e_ihit;
  logic [5:0]  e_code;
  logic [4:0]  e_iidx;

  function automatic void m_identity();
    m_tab.delete();
    for (int i = 0; i < DEPTH; i++) m_tab.push_back(i);
    m_cnt = 0;
  endfunction

  function automatic logic [255:0] m_flat();
    logic [255:0] f = '0;
    for (int i = 0; i < DEPTH; i++) f[i*CODE_W +: CODE_W] = 6'(m_tab[i]);
    return f;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit ld;
    ld = load && (table_idx == TBL_PLUGBOARD);
    if (!rst_n) begin
      e_rv = 0; e_code = 0; e_err = 0; e_stale = 0;
      e_irv = 0; e_iidx = 0; e_ihit = 0;
    end else begin
      e_rv = lookup_valid;
      if (lookup_valid) begin
        e_err   = (int'(lookup_idx) >= DEPTH);
        e_code  = e_err ? 6'd0 : 6'(m_tab[lookup_idx]);
        e_stale = (m_cnt != DEPTH);
      end
`ifdef SUBST_INVERSE_EN
      e_irv = inv_valid;
      if (inv_valid) begin
        e_ihit = 0;
        e_iidx = 0;
        for (int i = DEPTH-1; i >= 0; i--)
          if (m_tab[i] == int'(inv_code)) begin e_ihit = 1; e_iidx = 5'(i); end
      end
`endif
    end
    @(posedge clk);
    #1;
    if (!rst_n || clear) m_identity();
    else if (ld) begin
      m_tab.push_back(int'(code_in));
      void'(m_tab.pop_front());
      if (m_cnt < DEPTH) m_cnt++;
    end
    check("result_valid", 256'(result_valid), 256'(e_rv));
    check("result_code", 256'(result_code), 256'(e_code));
    check("result_err", 256'(result_err), 256'(e_err));
    check("result_stale", 256'(result_stale), 256'(e_stale));
    check("load_count", 256'(load_count), 256'(m_cnt));
    check("table_ready", 256'(table_ready), 256'(m_cnt == DEPTH));
    check("table_flat", 256'(table_flat), m_flat());
    check("inv_result_valid", 256'(inv_result_valid), 256'(e_irv));
    check("inv_idx", 256'(inv_idx), 256'(e_iidx));
    check("inv_hit", 256'(inv_hit), 256'(e_ihit));
  endtask

  task automatic idle();
    load = 0; clear = 0; lookup_valid = 0; inv_valid = 0; table_idx = TBL_PLUGBOARD;
  endtask

  initial begin
    m_identity();
    e_rv = 0; e_code = 0; e_err = 0; e_stale = 0; e_irv = 0; e_iidx = 0; e_ihit = 0;
    rst_n = 0; idle(); code_in = 0; lookup_idx = 0; inv_code = 0;
    #1;
    cycle(); cycle();

    // Reset state and stale lookup
    rst_n = 1; lookup_valid = 1; lookup_idx = 5;
    cycle();
    check("tp_reset_code", 256'(result_code), 256'd5);
    check("tp_reset_stale", 256'(result_stale), 256'd1);
    check("tp_reset_count", 256'(load_count), 256'd0);

    // Full load with codes 31-k
    for (int k = 0; k < DEPTH; k++) begin
      idle(); load = 1; code_in = 6'(31 - k);
      lookup_valid = 1'($urandom); lookup_idx = 5'($urandom);
      cycle();
    end
    check("tp_full_ready", 256'(table_ready), 256'd1);
    check("tp_full_count", 256'(load_count), 256'd32);
    idle(); lookup_valid = 1; lookup_idx = 3; inv_valid = 1; inv_code = 28;
    cycle();
    check("tp_full_lookup3", 256'(result_code), 256'd28);
    check("tp_full_stale", 256'(result_stale), 256'd0);
`ifdef SUBST_INVERSE_EN
    check("tp_inv_idx", 256'(inv_idx), 256'd3);
    check("tp_inv_hit", 256'(inv_hit), 256'd1);
`else
    check("tp_inv_off", 256'(inv_result_valid), 256'd0);
`endif

    // Wrong target
    idle(); load = 1; table_idx = TBL_REFLECTOR; code_in = 6'h3F;
    cycle();
    check("tp_wrong_count", 256'(load_count), 256'd32);
    check("tp_wrong_top", 256'(table_flat[191:186]), 256'd0);

    // Sliding window with coincident lookup
    idle(); load = 1; code_in = 6'h3F; lookup_valid = 1; lookup_idx = 0;
    cycle();
    check("tp_ovf_preshift", 256'(result_code), 256'd31);
    check("tp_ovf_top", 256'(table_flat[191:186]), 256'h3F);
    check("tp_ovf_bottom", 256'(table_flat[5:0]), 256'd30);
    check("tp_ovf_count", 256'(load_count), 256'd32);
    check("tp_ovf_ready", 256'(table_ready), 256'd1);

    // Clear, then reset, in the middle of a fill with a coincident load
    for (int pass = 0; pass < 2; pass++) begin
      idle(); clear = 1;
      cycle();
      for (int k = 0; k < 10; k++) begin
        idle(); load = 1; code_in = 6'($urandom);
        cycle();
      end
      idle(); load = 1; code_in = 6'h2A;
      if (pass == 0) clear = 1; else rst_n = 0;
      cycle();
      rst_n = 1;
      check("tp_mid_count", 256'(load_count), 256'd0);
      check("tp_mid_ready", 256'(table_ready), 256'd0);
      check("tp_mid_entry7", 256'(table_flat[7*CODE_W +: CODE_W]), 256'd7);
    end

    // Inverse miss on identity table
    idle(); inv_valid = 1; inv_code = 6'h3F;
    cycle();
    check("tp_inv_miss_hit", 256'(inv_hit), 256'd0);
    check("tp_inv_miss_idx", 256'(inv_idx), 256'd0);

    // Randomized traffic
    repeat (400) begin
      load         = ($urandom_range(0, 3) != 0);
      table_idx    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : TBL_PLUGBOARD;
      code_in      = $urandom_range(0, 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      clear        = ($urandom_range(0, 59) == 0);
      rst_n        = ($urandom_range(0, 149) != 0);
      lookup_valid = 1'($urandom);
      lookup_idx   = 5'($urandom);
      inv_valid    = 1'($urandom);
      inv_code     = $urandom_range(0, 1) ? 6'(m_tab[$urandom_range(0, DEPTH-1)]) : 6'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
